// File: rtl/drac_pkg.sv
// -----------------------------------------------------------------------------
// drac_pkg
// Shared vector-unit types: 64-bit data bus, element-width encoding and two
// small helpers that turn an element width into a bit count and a lane mask.
// -----------------------------------------------------------------------------
package drac_pkg;

  typedef logic [63:0] bus64_t;

  typedef enum logic [1:0] {
    SEW_8  = 2'b00,
    SEW_16 = 2'b01,
    SEW_32 = 2'b10,
    SEW_64 = 2'b11
  } sew_t;

  // Element width in bits (8, 16, 32 or 64).
  function automatic logic [6:0] sew_bits(input sew_t sew);
    return 7'd8 << sew;
  endfunction

  // Ones in bits [SEW-1:0], zeros above.
  function automatic bus64_t sew_mask(input sew_t sew);
    bus64_t mask;
    if (sew == SEW_64) mask = '1;
    else               mask = (64'd1 << sew_bits(sew)) - 64'd1;
    return mask;
  endfunction

endpackage

// File: rtl/vmul_2bits_step.sv
// -----------------------------------------------------------------------------
// vmul_2bits_step
// One radix-4 iteration of an unsigned shift-add multiplier (combinational).
// Ports:
//   i_acc   - upper half of the {acc, multiplier} shift register
//   i_mul   - lower half; its two LSBs select the partial product
//   i_a_mag - multiplicand magnitude
//   o_acc   - next upper half (after add and shift right by 2)
//   o_mul   - next lower half (after shift right by 2)
// -----------------------------------------------------------------------------
module vmul_2bits_step (
  input  logic [63:0] i_acc,
  input  logic [63:0] i_mul,
  input  logic [63:0] i_a_mag,
  output logic [63:0] o_acc,
  output logic [63:0] o_mul
);

  logic [65:0] w_pp;
  logic [65:0] w_sum;

  always_comb begin
    unique case (i_mul[1:0])
      2'd0:    w_pp = '0;
      2'd1:    w_pp = {2'b00, i_a_mag};
      2'd2:    w_pp = {1'b0, i_a_mag, 1'b0};
      default: w_pp = {2'b00, i_a_mag} + {1'b0, i_a_mag, 1'b0};
    endcase
    // 66-bit sum keeps the carries; the shift below folds them back into 64 bits.
    w_sum = {2'b00, i_acc} + w_pp;
    {o_acc, o_mul} = {w_sum, i_mul[63:2]};
  end

endmodule

// File: rtl/vmul_iter_2bits.sv
// -----------------------------------------------------------------------------
// vmul_iter_2bits
// Iterative SEW-bit integer multiplier retiring two multiplier bits per cycle.
// Operands are converted to magnitudes at accept, multiplied unsigned over
// SEW/2 cycles, and the sign is re-applied when the result is formed.
// Ports:
//   clk_i, rstn_i        - clock, asynchronous active-low reset
//   valid_i / ready_o    - request handshake (ready only while idle)
//   kill_i               - flush: aborts BUSY/DONE, blocks accept in IDLE
//   sew_i, signed_i,
//   high_i               - element width, signedness, high/low half select
//   multiplicand_i,
//   multiplier_i         - operands, bits [SEW-1:0] used
//   valid_o, result_o    - one-cycle result pulse, result zero-extended
// -----------------------------------------------------------------------------
module vmul_iter_2bits
  import drac_pkg::*;
(
  input  logic   clk_i,
  input  logic   rstn_i,
  input  logic   valid_i,
  output logic   ready_o,
  input  logic   kill_i,
  input  sew_t   sew_i,
  input  logic   signed_i,
  input  logic   high_i,
  input  bus64_t multiplicand_i,
  input  bus64_t multiplier_i,
  output logic   valid_o,
  output bus64_t result_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e       r_state;
  logic [4:0]   r_cnt;
  logic [63:0]  r_acc;
  logic [63:0]  r_mul;
  logic [63:0]  r_a_mag;
  logic         r_neg;
  logic         r_high;
  sew_t         r_sew;
  bus64_t       r_result;

  bus64_t       w_mask_in;
  logic [5:0]   w_msb_in;
  logic         w_a_neg;
  logic         w_b_neg;
  logic [63:0]  w_a_mag;
  logic [63:0]  w_b_mag;
  logic [4:0]   w_cnt_init;

  logic [63:0]  w_acc_nx;
  logic [63:0]  w_mul_nx;
  logic [6:0]   w_shamt;
  logic [127:0] w_full;
  logic [127:0] w_prod;
  logic [127:0] w_hi;
  bus64_t       w_res;

  // Operand conditioning at accept: extend from SEW, then take magnitudes.
  always_comb begin
    w_mask_in  = sew_mask(sew_i);
    w_msb_in   = 6'(sew_bits(sew_i) - 7'd1);
    w_a_neg    = signed_i & multiplicand_i[w_msb_in];
    w_b_neg    = signed_i & multiplier_i[w_msb_in];
    // Negating the sign-extended value; the SEW=64 minimum yields 2^63 unsigned.
    w_a_mag    = w_a_neg ? (64'd0 - (multiplicand_i | ~w_mask_in))
                         : (multiplicand_i & w_mask_in);
    w_b_mag    = w_b_neg ? (64'd0 - (multiplier_i | ~w_mask_in))
                         : (multiplier_i & w_mask_in);
    w_cnt_init = 5'((sew_bits(sew_i) >> 1) - 7'd1);
  end

  vmul_2bits_step u_step (
    .i_acc   (r_acc),
    .i_mul   (r_mul),
    .i_a_mag (r_a_mag),
    .o_acc   (w_acc_nx),
    .o_mul   (w_mul_nx)
  );

  // After SEW bits are consumed the 2*SEW product sits left-aligned at bit 64+SEW.
  always_comb begin
    w_shamt = 7'd64 - sew_bits(r_sew);
    w_full  = {w_acc_nx, w_mul_nx} >> w_shamt;
    w_prod  = r_neg ? (128'd0 - w_full) : w_full;
    w_hi    = w_prod >> sew_bits(r_sew);
    w_res   = (r_high ? w_hi[63:0] : w_prod[63:0]) & sew_mask(r_sew);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mul    <= '0;
      r_a_mag  <= '0;
      r_neg    <= 1'b0;
      r_high   <= 1'b0;
      r_sew    <= SEW_8;
      r_result <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (valid_i && !kill_i) begin
            r_state <= StBusy;
            r_cnt   <= w_cnt_init;
            r_acc   <= '0;
            r_mul   <= w_b_mag;
            r_a_mag <= w_a_mag;
            r_neg   <= w_a_neg ^ w_b_neg;
            r_high  <= high_i;
            r_sew   <= sew_i;
          end
        end
        StBusy: begin
          if (kill_i) begin
            r_state <= StIdle;
          end else begin
            r_acc <= w_acc_nx;
            r_mul <= w_mul_nx;
            if (r_cnt == 5'd0) begin
              r_state  <= StDone;
              r_result <= w_res;
            end else begin
              r_cnt <= r_cnt - 5'd1;
            end
          end
        end
        StDone:  r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ready_o  = (r_state == StIdle);
  // A flush arriving in the DONE cycle suppresses the pulse.
  assign valid_o  = (r_state == StDone) & ~kill_i;
  assign result_o = r_result;

endmodule

// File: tb/tb_vmul_iter_2bits.sv
// Scoreboard bench: the driver pushes expected results (value and due cycle)
// at accept; a negedge monitor pops and compares whenever valid_o is seen.
module tb_vmul_iter_2bits;
  import drac_pkg::*;

  logic   clk_i = 1'b0;
  logic   rstn_i = 1'b0;
  logic   valid_i = 1'b0;
  logic   kill_i = 1'b0;
  sew_t   sew_i = SEW_8;
  logic   signed_i = 1'b0;
  logic   high_i = 1'b0;
  bus64_t multiplicand_i = '0;
  bus64_t multiplier_i = '0;
  logic   ready_o;
  logic   valid_o;
  bus64_t result_o;

  vmul_iter_2bits dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .kill_i         (kill_i),
    .sew_i          (sew_i),
    .signed_i       (signed_i),
    .high_i         (high_i),
    .multiplicand_i (multiplicand_i),
    .multiplier_i   (multiplier_i),
    .valid_o        (valid_o),
    .result_o       (result_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] res;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [63:0] hold = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Reference: plain wide-integer multiply of the extended operands.
  function automatic logic [63:0] ref_mul(input int w, input bit sg, input bit hi,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] m, ea, eb, p;
    m  = (128'd1 << w) - 128'd1;
    ea = {64'd0, a} & m;
    eb = {64'd0, b} & m;
    if (sg && ea[w-1]) ea = ea | ~m;
    if (sg && eb[w-1]) eb = eb | ~m;
    p = ea * eb;
    if (hi) p = p >> w;
    p = p & m;
    return p[63:0];
  endfunction

  // Monitor: one sample per cycle, mid-cycle.
  initial begin
    forever begin
      @(negedge clk_i);
      cyc++;
      if (rstn_i) begin
        if (valid_o) begin
          if (q.size() == 0) begin
            check("unexpected_valid", 64'(valid_o), 64'd0);
          end else begin
            exp_t e;
            e = q.pop_front();
            check("result", result_o, e.res);
            check("latency_cycle", 64'(cyc), 64'(e.due));
            hold = e.res;
          end
        end else begin
          check("result_hold", result_o, hold);
        end
      end
    end
  end

  // Called at posedge+#1. Returns after the accept edge, at posedge+#1.
  task automatic issue(input sew_t s, input bit sg, input bit hi, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input bit push);
    int guard = 0;
    int w;
    exp_t e;
    w = 8 << int'(s);
    while (!ready_o && guard < 200) begin
      @(posedge clk_i); #1;
      guard++;
    end
    if (!ready_o) begin
      check("ready_timeout", 64'(ready_o), 64'd1);
      return;
    end
    valid_i = 1'b1; sew_i = s; signed_i = sg; high_i = hi;
    multiplicand_i = a; multiplier_i = b;
    @(posedge clk_i);
    if (push) begin
      e.res = exp;
      e.due = cyc + w / 2 + 1;
      q.push_back(e);
    end
    #1;
    valid_i = 1'b0;
    multiplicand_i = {$urandom, $urandom};
    multiplier_i = {$urandom, $urandom};
    check("busy_not_ready", 64'(ready_o), 64'd0);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
    end
  endtask

  initial begin
    int guard;
    #1;
    check("reset_ready", 64'(ready_o), 64'd1);
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    idle_cycles(3);
    rstn_i = 1'b1;
    idle_cycles(2);

    // Directed cases
    issue(SEW_8, 1'b0, 1'b0, 64'hFF, 64'hFF, 64'h01, 1'b1);
    issue(SEW_8, 1'b0, 1'b1, 64'hFF, 64'hFF, 64'hFE, 1'b1);
    issue(SEW_16, 1'b1, 1'b0, 64'hA5A5_0000_0000_FFFD, 64'h1234_0000_0000_0007, 64'hFFEB, 1'b1);
    issue(SEW_16, 1'b1, 1'b1, 64'h0000_0000_0000_FFFD, 64'h0000_0000_0000_0007, 64'hFFFF, 1'b1);
    issue(SEW_64, 1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
          64'h4000_0000_0000_0000, 1'b1);
    issue(SEW_64, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, 1'b1);
    issue(SEW_32, 1'b0, 1'b0, 64'hDEADBEEF_00000003, 64'h12345678_00000005, 64'hF, 1'b1);
    issue(SEW_8, 1'b1, 1'b1, 64'h80, 64'h80, 64'h40, 1'b1);
    issue(SEW_8, 1'b1, 1'b0, 64'h80, 64'h80, 64'h00, 1'b1);
    issue(SEW_32, 1'b1, 1'b1, 64'hFFFF_FFFF, 64'h0000_0002, 64'hFFFF_FFFF, 1'b1);

    // Kill in IDLE blocks the accept
    guard = 0;
    while (!ready_o && guard < 200) begin
      @(posedge clk_i); #1;
      guard++;
    end
    valid_i = 1'b1; kill_i = 1'b1; sew_i = SEW_8;
    multiplicand_i = 64'h3; multiplier_i = 64'h3;
    @(posedge clk_i); #1;
    valid_i = 1'b0; kill_i = 1'b0;
    check("kill_blocks_accept", 64'(ready_o), 64'd1);
    idle_cycles(10);

    // Kill in the third BUSY cycle: no pulse, ready the cycle after
    issue(SEW_16, 1'b0, 1'b0, 64'h1234, 64'h5678, 64'd0, 1'b0);
    idle_cycles(2);
    kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    check("kill_ready", 64'(ready_o), 64'd1);
    idle_cycles(12);
    issue(SEW_8, 1'b0, 1'b0, 64'd6, 64'd7, 64'h2A, 1'b1);

    // Asynchronous reset mid-BUSY
    issue(SEW_32, 1'b0, 1'b0, 64'h1111_2222, 64'h3333_4444, 64'd0, 1'b0);
    idle_cycles(4);
    #1;
    rstn_i = 1'b0;
    #1;
    check("async_rst_ready", 64'(ready_o), 64'd1);
    check("async_rst_valid", 64'(valid_o), 64'd0);
    check("async_rst_result", result_o, 64'd0);
    hold = '0;
    #1;
    rstn_i = 1'b1;
    idle_cycles(25);

    // Randomized traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      sew_t        s;
      bit          sg, hi;
      logic [63:0] a, b;
      int          w;
      s  = sew_t'($urandom_range(0, 3));
      w  = 8 << int'(s);
      sg = 1'($urandom_range(0, 1));
      hi = 1'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) a = 64'd1 << (w - 1);
      if ($urandom_range(0, 7) == 0) b = 64'd1 << (w - 1);
      if ($urandom_range(0, 9) == 0) a = '1;
      issue(s, sg, hi, a, b, ref_mul(w, sg, hi, a, b), 1'b1);
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
    end

    // Drain
    guard = 0;
    while (q.size() != 0 && guard < 200) begin
      @(posedge clk_i); #1;
      guard++;
    end
    idle_cycles(2);
    check("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vmul_iter_2bits.md
VMUL_ITER_2BITS -- requirements
Module: vmul_iter_2bits

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port rstn_i, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port valid_i, input, 1 bit: request valid.
REQ-004 SHALL have port ready_o, output, 1 bit: block idle, can accept a request.
REQ-005 SHALL have port kill_i, input, 1 bit: abort the current operation (pipeline flush).
REQ-006 SHALL have port sew_i, input, sew_t: element width (SEW_8/16/32/64), sampled at accept.
REQ-007 SHALL have port signed_i, input, 1 bit: operands are two's-complement, sampled at accept.
REQ-008 SHALL have port high_i, input, 1 bit: return high half (1) or low half (0) of the 2*SEW product, sampled at accept.
REQ-009 SHALL have port multiplicand_i, input, bus64_t: operand A; only bits [SEW-1:0] used.
REQ-010 SHALL have port multiplier_i, input, bus64_t: operand B; only bits [SEW-1:0] used.
REQ-011 SHALL have port valid_o, output, 1 bit: result valid, one-cycle pulse.
REQ-012 SHALL have port result_o, output, bus64_t: result in [SEW-1:0], bits [63:SEW] zero.

Function
REQ-013 SHALL implement FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-014 ready_o SHALL be 1 only in IDLE; a request is accepted on an edge where valid_i=1, ready_o=1 and kill_i=0.
REQ-015 At accept, operands SHALL be sign-extended (signed_i=1) or zero-extended from SEW, converted to magnitudes, and the result sign (sign A XOR sign B) latched.
REQ-016 BUSY SHALL last exactly SEW/2 cycles; each cycle consumes the 2 LSBs of the multiplier magnitude, adds {0,1,2,3}*|A| to the upper accumulator half (66-bit sum, no overflow loss), and shifts the 128-bit {acc, multiplier} register right by 2.
REQ-017 The iteration counter SHALL load SEW/2-1 at accept and move BUSY->DONE when it reaches 0.
REQ-018 In DONE, the 2*SEW-bit product SHALL be negated if the latched sign is 1, the SEW-bit half selected by high_i placed in result_o, and valid_o=1 for exactly that cycle.
REQ-019 Latency SHALL be SEW/2+1 cycles from the accept edge to the cycle where valid_o=1 (SEW_8: 5, SEW_64: 33).
REQ-020 result_o SHALL hold its value until the next DONE; no new accept in DONE, earliest next accept is the cycle after DONE.
REQ-021 kill_i=1 in BUSY or DONE SHALL return the FSM to IDLE on the next edge with no valid_o pulse; kill_i with valid_i in IDLE SHALL block the accept.
REQ-022 Signed overflow corner (most negative × most negative) SHALL produce the exact 2*SEW-bit product.

Reset
REQ-023 On rstn_i=0: FSM=IDLE, counter=0, accumulator=0, ready_o=1, valid_o=0, result_o=0, immediately and independent of clk_i, including mid-operation.

Structure
REQ-024 sew_t, bus64_t and the SEW_* encodings SHALL come from drac_pkg; no new package types.
REQ-025 The combinational step (partial-product select, add, shift by 2) SHALL be the sub-module vmul_2bits_step; the FSM, counter and sign logic SHALL stay in vmul_iter_2bits.

Verification
REQ-026 SEW_8 unsigned 0xFF*0xFF: high_i=0 -> 0x01, high_i=1 -> 0xFE; valid_o in 5th cycle after accept.
REQ-027 SEW_16 signed 0xFFFD*0x0007 (-3*7): low -> 0xFFEB, high -> 0xFFFF.
REQ-028 SEW_64 signed high 0x8000_0000_0000_0000 squared -> 0x4000_0000_0000_0000 (low -> 0); valid_o after 33 cycles.
REQ-029 SEW_32 unsigned 0xDEADBEEF_00000003 * 0x12345678_00000005 -> result_o=0x0000_0000_0000_000F (upper input bits ignored).
REQ-030 kill_i at 3rd BUSY cycle -> no valid_o, ready_o=1 next cycle; a following SEW_8 6*7 request -> 0x2A.
REQ-031 rstn_i low mid-BUSY -> ready_o=1, valid_o=0, result_o=0 without a clock edge; no spurious valid_o after release.
